// File: rtl/adder_pkg.sv
// Shared types and helpers for the carry-segmented pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ADDS = 2'd2,
    SUBS = 2'd3
  } op_e;

  // Per-stage control: beat valid, operation, carry out of the segment just added
  typedef struct packed {
    logic valid;
    op_e  op;
    logic carry;
  } stage_t;

  function automatic logic is_sub(op_e op);
    return (op == SUB) || (op == SUBS);
  endfunction

  function automatic logic is_sat(op_e op);
    return (op == ADDS) || (op == SUBS);
  endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Stream handshake bundle between an operand producer, adder_pipe and a result consumer.
interface adder_pipe_if
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  op_e              op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             ovf_o;

  modport master (
    output in_valid_i, a_i, b_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, carry_o, ovf_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, carry_o, ovf_o
  );

endinterface

// File: rtl/adder_seg.sv
// One SEG-bit add-with-carry slice; purely combinational.
module adder_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s     = total[SEG-1:0];
  assign co    = total[SEG];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: the carry chain is split into STAGES segments, one per
// cycle, with pending operand bits skewed forward and finished bits carried along.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  adder_pipe_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NB  = (STAGES > 1) ? STAGES - 1 : 1;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > 8) begin : g_param_check
    $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES must be 1..8");
  end

  stage_t           st_q  [STAGES];
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] bop_q [NB];
  logic             ovf_q;
  logic             advance;

  // Whole pipeline moves in lockstep, bubbles included, unless the output is blocked
  assign advance         = !st_q[STAGES-1].valid || bus.out_ready_i;
  assign bus.in_ready_o  = advance;
  assign bus.out_valid_o = st_q[STAGES-1].valid;
  assign bus.sum_o       = acc_q[STAGES-1];
  assign bus.carry_o     = st_q[STAGES-1].carry;
  assign bus.ovf_o       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           st_in;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] bop_in;
    logic [WIDTH-1:0] acc_nxt;
    logic [SEG-1:0]   seg_sum;
    logic             seg_co;

    if (k == 0) begin : g_head
      assign st_in  = '{valid: bus.in_valid_i, op: bus.op_i, carry: is_sub(bus.op_i)};
      assign acc_in = bus.a_i;
      assign bop_in = is_sub(bus.op_i) ? ~bus.b_i : bus.b_i;
    end else begin : g_body
      assign st_in  = st_q[k-1];
      assign acc_in = acc_q[k-1];
      assign bop_in = bop_q[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a  (acc_in[k*SEG +: SEG]),
      .b  (bop_in[k*SEG +: SEG]),
      .ci (st_in.carry),
      .s  (seg_sum),
      .co (seg_co)
    );

    always_comb begin
      acc_nxt                 = acc_in;
      acc_nxt[k*SEG +: SEG]   = seg_sum;
    end

    if (k == STAGES - 1) begin : g_tail
      logic [WIDTH-1:0] sat_sum;
      logic             carry_rep;
      logic             raw_ovf;

      // Top segment still holds raw A and B' in its MSB, so overflow needs no extra carry tap
      assign raw_ovf   = acc_in[WIDTH-1] ^ bop_in[WIDTH-1] ^ seg_sum[SEG-1] ^ seg_co;
      assign carry_rep = is_sub(st_in.op) ? !seg_co : seg_co;

      always_comb begin
        sat_sum = acc_nxt;
        if (is_sat(st_in.op) && carry_rep) begin
          sat_sum = is_sub(st_in.op) ? '0 : '1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          st_q[k]  <= '0;
          acc_q[k] <= '0;
          ovf_q    <= 1'b0;
        end else if (advance) begin
          st_q[k]  <= '{valid: st_in.valid, op: st_in.op, carry: carry_rep};
          acc_q[k] <= sat_sum;
          ovf_q    <= raw_ovf;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          st_q[k]  <= '0;
          acc_q[k] <= '0;
          bop_q[k] <= '0;
        end else if (advance) begin
          st_q[k]  <= '{valid: st_in.valid, op: st_in.op, carry: seg_co};
          acc_q[k] <= acc_nxt;
          bop_q[k] <= bop_in;
        end
      end
    end
  end

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.out_valid_o && !bus.out_ready_i) |=>
      (bus.out_valid_o && $stable(bus.sum_o) && $stable(bus.carry_o) && $stable(bus.ovf_o)))
    else $error("adder_pipe: output changed while stalled");

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and randomised-stream checks for adder_pipe (32-bit/4-stage and 8-bit/1-stage).
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(W)) bus ();
  adder_pipe_if #(.WIDTH(8)) bus8 ();

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid_i = 1'b1;
    bus.op_i       = op;
    bus.a_i        = a;
    bus.b_i        = b;
  endtask

  // Independent reference: full-width arithmetic, sign-rule overflow
  function automatic logic [W+1:0] refModel(input op_e op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] s;
    logic         c;
    logic         v;
    if (op == SUB || op == SUBS) begin
      s = a - b;
      c = (a < b);
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      {c, s} = {1'b0, a} + {1'b0, b};
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    if (op == ADDS && c) s = '1;
    if (op == SUBS && c) s = '0;
    return {s, c, v};
  endfunction

  task automatic runDirected(input string tag, input op_e op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] es,
                             input logic ec, input logic ev);
    @(negedge clk);
    applyStimulus(op, a, b);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (S - 2) @(negedge clk);
    checkOutput({tag, " early"}, bus.out_valid_o, 64'd0);
    @(negedge clk);
    checkOutput({tag, " valid"}, bus.out_valid_o, 64'd1);
    checkOutput({tag, " result"}, {bus.sum_o, bus.carry_o, bus.ovf_o}, {es, ec, ev});
  endtask

  initial begin
    logic [W+1:0] q[$];
    logic [W+1:0] held;
    logic         stall;
    logic         expReady;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    op_e          rop;
    int           accepted;
    int           consumed;
    int           cycles;
    int           extra;

    bus.in_valid_i  = 1'b0;
    bus.op_i        = ADD;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.out_ready_i = 1'b1;
    bus8.in_valid_i  = 1'b0;
    bus8.op_i        = ADD;
    bus8.a_i         = '0;
    bus8.b_i         = '0;
    bus8.out_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", bus.out_valid_o, 64'd0);
    checkOutput("reset outputs", {bus.sum_o, bus.carry_o, bus.ovf_o}, 64'd0);
    checkOutput("reset in_ready", bus.in_ready_o, 64'd1);
    rst_n = 1'b1;

    runDirected("add wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    runDirected("sub borrow", SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0);
    runDirected("subs clamp", SUBS, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
    runDirected("adds clamp", ADDS, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    runDirected("add ovf", ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    runDirected("sub plain", SUB, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
    runDirected("adds pass", ADDS, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
    runDirected("subs ovf", SUBS, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    runDirected("seg carry", ADD, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, 1'b0);

    // Random stream with stalls and gaps against the reference queue
    accepted = 0;
    consumed = 0;
    cycles   = 0;
    stall    = 1'b0;
    held     = '0;
    while ((accepted < 100 || q.size() > 0) && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (stall) begin
        checkOutput("stall hold", {bus.out_valid_o, bus.sum_o, bus.carry_o, bus.ovf_o},
                    {1'b1, held});
      end
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (q.size() == 0) begin
          checkOutput("spurious result", bus.out_valid_o, 64'd0);
        end else begin
          checkOutput("stream result", {bus.sum_o, bus.carry_o, bus.ovf_o}, q.pop_front());
          consumed++;
        end
      end
      stall = bus.out_valid_o && !bus.out_ready_i;
      held  = {bus.sum_o, bus.carry_o, bus.ovf_o};
      expReady = !bus.out_valid_o || bus.out_ready_i;
      if (accepted < 100 && $urandom_range(0, 4) != 0) begin
        rop = op_e'($urandom_range(0, 3));
        ra  = $urandom;
        rb  = $urandom;
        if ($urandom_range(0, 3) == 0) rb = ra;
        applyStimulus(rop, ra, rb);
      end else begin
        bus.in_valid_i = 1'b0;
      end
      #1;
      checkOutput("in_ready", bus.in_ready_o, {63'd0, expReady});
      if (bus.in_valid_i && expReady) begin
        q.push_back(refModel(rop, ra, rb));
        accepted++;
      end
    end
    checkOutput("stream count", consumed, 64'd100);
    checkOutput("stream drained", q.size(), 64'd0);

    @(negedge clk);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (S + 1) @(negedge clk);

    // Reset with beats in flight
    for (int i = 0; i < S; i++) begin
      applyStimulus(ADD, 32'(i + 1), 32'd10);
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    checkOutput("pre-reset valid", bus.out_valid_o, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset drop valid", bus.out_valid_o, 64'd0);
    checkOutput("reset drop outputs", {bus.sum_o, bus.carry_o, bus.ovf_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runDirected("post-reset", ADD, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 1'b0, 1'b0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid_o) extra++;
    end
    checkOutput("post-reset extra", extra, 64'd0);

    // Single-stage 8-bit instance
    @(negedge clk);
    bus8.in_valid_i = 1'b1;
    bus8.op_i       = ADD;
    bus8.a_i        = 8'hF0;
    bus8.b_i        = 8'h20;
    checkOutput("w8 idle", bus8.out_valid_o, 64'd0);
    @(negedge clk);
    bus8.in_valid_i = 1'b0;
    checkOutput("w8 valid", bus8.out_valid_o, 64'd1);
    checkOutput("w8 result", {bus8.sum_o, bus8.carry_o, bus8.ovf_o}, {8'h10, 1'b1, 1'b0});
    @(negedge clk);
    checkOutput("w8 consumed", bus8.out_valid_o, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
